// File: rtl/n2_imem_arbiter.sv
// n2_imem_arbiter: shares one 64-bit instruction SRAM port between the
// two-issue fetch unit and the loader/debug requester.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   flush_i                   redirect; squashes fetch responses in flight
//   if_req_i/if_req_2b_i/if_addr_i -> if_gnt_o      fetch request / grant
//   if_rvalid_o/if_rdata_o    per-slot fetch response, slot 0 = requested word
//   cfg_req_i/cfg_we_i/cfg_addr_i/cfg_wdata_i -> cfg_gnt_o   loader request / grant
//   cfg_rvalid_o/cfg_rdata_o  loader read response
//   hold_i                    loader-exclusive mode
//   mem_*                     SRAM port, read data MEM_LAT cycles after request
module n2_imem_arbiter #(
  parameter int MEM_LAT       = 1,
  parameter int CFG_BURST_MAX = 4,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [1:0]        if_req_2b_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic [1:0]        if_rvalid_o,
  output logic [63:0]       if_rdata_o,
  input  logic              cfg_req_i,
  input  logic              cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic              cfg_gnt_o,
  output logic              cfg_rvalid_o,
  output logic [31:0]       cfg_rdata_o,
  input  logic              hold_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_be_o,
  output logic [ADDR_W-4:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i
);

  localparam int CW = $clog2(CFG_BURST_MAX + 1);

  typedef enum logic { RUN, HOLD } state_t;

  // One in-flight read; fetch=0 means loader read.
  typedef struct packed {
    logic       fetch;
    logic [1:0] mask;
    logic       hi;
    logic       squash;
  } ent_t;

  state_t          state;
  logic [CW-1:0]   burst_cnt;
  logic            burst_full, fetch_ok, rd_gnt, fetch_pend;
  logic [ADDR_W-1:0] gnt_addr;
  ent_t            new_ent, last;
  logic [MEM_LAT:1] vld_pipe;
  ent_t            ent_pipe [1:MEM_LAT];
  logic            unused;

  assign unused = ^{if_addr_i[1:0], cfg_addr_i[1:0]};

  // Grants: loader first, fetch forced through once the loader has had
  // CFG_BURST_MAX back-to-back grants against a waiting fetch. Fetch is
  // blocked during flush, while hold_i is up (covers draining) and in HOLD.
  assign burst_full = (burst_cnt == CW'(CFG_BURST_MAX));
  assign fetch_ok   = if_req_i & ~flush_i & ~hold_i & (state == RUN);
  assign if_gnt_o   = ~rst & fetch_ok & (~cfg_req_i | burst_full);
  assign cfg_gnt_o  = ~rst & cfg_req_i & ~(fetch_ok & burst_full);
  assign rd_gnt     = if_gnt_o | (cfg_gnt_o & ~cfg_we_i);
  assign gnt_addr   = if_gnt_o ? if_addr_i : cfg_addr_i;

  always_comb begin
    mem_req_o   = if_gnt_o | cfg_gnt_o;
    mem_we_o    = cfg_gnt_o & cfg_we_i;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o = gnt_addr[ADDR_W-1:3];
      mem_be_o   = 8'hFF;
    end
    if (mem_we_o) begin
      mem_be_o    = gnt_addr[2] ? 8'hF0 : 8'h0F;
      mem_wdata_o = {cfg_wdata_i, cfg_wdata_i};
    end
  end

  // An odd-word fetch only has one valid instruction in the doubleword.
  always_comb begin
    new_ent        = '0;
    new_ent.fetch  = if_gnt_o;
    new_ent.hi     = gnt_addr[2];
    if (if_gnt_o)
      new_ent.mask = if_addr_i[2] ? {1'b0, if_req_2b_i[0]} : if_req_2b_i;
  end

  // Response pipeline: stage MEM_LAT lines up with mem_rdata_i. A flush marks
  // every fetch entry still moving down the pipe; the entry leaving this
  // cycle has already been delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 1; i <= MEM_LAT; i++) ent_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= rd_gnt;
      ent_pipe[1] <= new_ent;
      for (int i = 2; i <= MEM_LAT; i++) begin
        vld_pipe[i]        <= vld_pipe[i-1];
        ent_pipe[i]        <= ent_pipe[i-1];
        ent_pipe[i].squash <= ent_pipe[i-1].squash | (flush_i & ent_pipe[i-1].fetch);
      end
    end
  end

  always_comb begin
    fetch_pend = 1'b0;
    for (int i = 1; i <= MEM_LAT; i++)
      fetch_pend = fetch_pend | (vld_pipe[i] & ent_pipe[i].fetch & ~ent_pipe[i].squash);
  end

  // HOLD only once no live fetch response remains; leaves a cycle after hold_i drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      burst_cnt <= '0;
    end else begin
      case (state)
        RUN:  if (hold_i && !fetch_pend) state <= HOLD;
        HOLD: if (!hold_i) state <= RUN;
        default: state <= RUN;
      endcase
      if (!if_req_i || if_gnt_o)
        burst_cnt <= '0;
      else if (cfg_gnt_o && !burst_full)
        burst_cnt <= burst_cnt + CW'(1);
    end
  end

  assign last = ent_pipe[MEM_LAT];

  always_comb begin
    if_rvalid_o  = '0;
    if_rdata_o   = '0;
    cfg_rvalid_o = 1'b0;
    cfg_rdata_o  = '0;
    if (vld_pipe[MEM_LAT]) begin
      if (last.fetch) begin
        if (!last.squash) begin
          if_rvalid_o = last.mask;
          if_rdata_o  = last.hi ? {32'h0, mem_rdata_i[63:32]} : mem_rdata_i;
        end
      end else begin
        cfg_rvalid_o = 1'b1;
        cfg_rdata_o  = last.hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      end
    end
  end

endmodule

// File: tb/tb_n2_imem_arbiter.sv
// Bench for n2_imem_arbiter (MEM_LAT=2, CFG_BURST_MAX=4): directed pins plus
// random traffic compared every cycle against a queue-based reference model.
module tb_n2_imem_arbiter;
  localparam int LAT = 2, BMAX = 4, AW = 32;

  logic clk = 0, rst = 1;
  logic flush_i = 0, if_req_i = 0, cfg_req_i = 0, cfg_we_i = 0, hold_i = 0;
  logic [1:0] if_req_2b_i = 0;
  logic [AW-1:0] if_addr_i = 0, cfg_addr_i = 0;
  logic [31:0] cfg_wdata_i = 0;
  logic [63:0] mem_rdata_i = 0;
  logic if_gnt_o, cfg_gnt_o, cfg_rvalid_o, mem_req_o, mem_we_o;
  logic [1:0] if_rvalid_o;
  logic [63:0] if_rdata_o, mem_wdata_o;
  logic [31:0] cfg_rdata_o;
  logic [7:0] mem_be_o;
  logic [AW-4:0] mem_addr_o;

  n2_imem_arbiter #(.MEM_LAT(LAT), .CFG_BURST_MAX(BMAX), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_req_2b_i(if_req_2b_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .hold_i(hold_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i));

  always #5 clk = ~clk;

  typedef struct { int g; bit f; bit [1:0] m; bit hi; bit sq; } rec_t;
  typedef struct { string nm; logic [63:0] v; } pin_t;

  rec_t mq[$];      // reads in flight, oldest first
  pin_t pins[$];    // hand-computed expectations for the current cycle
  int errs = 0, chks = 0, cyc = 0, mcnt = 0;
  bit mhold = 0;

  function automatic logic [63:0] act_of(string n);
    if (n == "if_gnt")     return 64'(if_gnt_o);
    if (n == "cfg_gnt")    return 64'(cfg_gnt_o);
    if (n == "if_rvalid")  return 64'(if_rvalid_o);
    if (n == "if_rdata")   return if_rdata_o;
    if (n == "cfg_rvalid") return 64'(cfg_rvalid_o);
    if (n == "cfg_rdata")  return 64'(cfg_rdata_o);
    if (n == "mem_req")    return 64'(mem_req_o);
    if (n == "mem_we")     return 64'(mem_we_o);
    if (n == "mem_be")     return 64'(mem_be_o);
    if (n == "mem_addr")   return 64'(mem_addr_o);
    if (n == "mem_wdata")  return mem_wdata_o;
    return '1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Compare process: model expectations and directed pins, every cycle.
  always @(negedge clk) begin : cmp_p
    bit fok, e_ifg, e_cfg, e_we, due, outst;
    logic [63:0] e_rd, e_wd;
    logic [31:0] e_crd, a;
    logic [7:0] e_be;
    logic [1:0] e_rv;
    bit e_crv;
    rec_t r;
    cyc++;
    e_ifg = 0; e_cfg = 0; e_we = 0; e_be = 0; e_wd = 0; e_rv = 0; e_rd = 0;
    e_crv = 0; e_crd = 0; a = 0; due = 0;
    if (rst) begin
      mq.delete(); mcnt = 0; mhold = 0;
    end else begin
      fok   = if_req_i && !flush_i && !hold_i && !mhold;
      e_ifg = fok && (!cfg_req_i || mcnt == BMAX);
      e_cfg = cfg_req_i && !(fok && mcnt == BMAX);
      e_we  = e_cfg && cfg_we_i;
      a     = e_ifg ? if_addr_i : (e_cfg ? cfg_addr_i : 32'h0);
      e_be  = e_we ? (a[2] ? 8'hF0 : 8'h0F) : ((e_ifg || e_cfg) ? 8'hFF : 8'h00);
      e_wd  = e_we ? {cfg_wdata_i, cfg_wdata_i} : 64'h0;
      due   = (mq.size() > 0) && (mq[0].g == cyc - LAT);
      if (due) begin
        r = mq[0];
        if (r.f && !r.sq) begin
          e_rv = r.m;
          e_rd = r.hi ? {32'h0, mem_rdata_i[63:32]} : mem_rdata_i;
        end else if (!r.f) begin
          e_crv = 1;
          e_crd = r.hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        end
      end
    end
    chk("if_gnt", 64'(if_gnt_o), 64'(e_ifg));
    chk("cfg_gnt", 64'(cfg_gnt_o), 64'(e_cfg));
    chk("mem_req", 64'(mem_req_o), 64'(e_ifg || e_cfg));
    chk("mem_we", 64'(mem_we_o), 64'(e_we));
    chk("mem_be", 64'(mem_be_o), 64'(e_be));
    chk("mem_addr", 64'(mem_addr_o), 64'(a >> 3));
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("if_rvalid", 64'(if_rvalid_o), 64'(e_rv));
    chk("if_rdata", if_rdata_o, e_rd);
    chk("cfg_rvalid", 64'(cfg_rvalid_o), 64'(e_crv));
    chk("cfg_rdata", 64'(cfg_rdata_o), 64'(e_crd));
    foreach (pins[i]) chk({"pin_", pins[i].nm}, act_of(pins[i].nm), pins[i].v);
    pins.delete();
    if (!rst) begin
      outst = 0;
      foreach (mq[i]) if (mq[i].f && !mq[i].sq) outst = 1;
      if (due) void'(mq.pop_front());
      foreach (mq[i]) if (mq[i].f && flush_i) mq[i].sq = 1;
      if (e_ifg || (e_cfg && !cfg_we_i)) begin
        r.g = cyc; r.f = e_ifg; r.hi = a[2]; r.sq = 0;
        r.m = e_ifg ? (if_addr_i[2] ? {1'b0, if_req_2b_i[0]} : if_req_2b_i) : 2'b00;
        mq.push_back(r);
      end
      mhold = mhold ? hold_i : (hold_i && !outst);
      if (!if_req_i || e_ifg) mcnt = 0;
      else if (e_cfg && mcnt < BMAX) mcnt++;
    end
  end

  task automatic pin(string nm, logic [63:0] v);
    pin_t p;
    p.nm = nm; p.v = v;
    pins.push_back(p);
  endtask

  // Start of a cycle: request inputs idle, fresh SRAM data.
  task automatic tick();
    @(posedge clk); #1;
    flush_i = 0; if_req_i = 0; if_req_2b_i = 0; if_addr_i = 0;
    cfg_req_i = 0; cfg_we_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0;
    mem_rdata_i = {$urandom, $urandom};
  endtask

  task automatic fetch(logic [31:0] ad, logic [1:0] m);
    if_req_i = 1; if_addr_i = ad; if_req_2b_i = m;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // aligned dual fetch
    tick(); fetch(32'h100, 2'b11);
    pin("if_gnt", 1); pin("mem_req", 1); pin("mem_be", 64'hFF); pin("mem_addr", 64'h20);
    tick();
    tick(); mem_rdata_i = 64'hBBBB_0000_AAAA_0000;
    pin("if_rvalid", 3); pin("if_rdata", 64'hBBBB_0000_AAAA_0000);
    // odd-word fetch drops slot 1
    tick(); fetch(32'h104, 2'b11); pin("mem_be", 64'hFF); pin("mem_addr", 64'h20);
    tick();
    tick(); mem_rdata_i = 64'h1111_2222_3333_4444;
    pin("if_rvalid", 1); pin("if_rdata", 64'h0000_0000_1111_2222);
    repeat (3) tick();
    // loader burst against a waiting fetch
    for (int i = 0; i < 10; i++) begin
      tick(); fetch(32'h40, 2'b01); cfg_req_i = 1; cfg_addr_i = 32'h10;
      pin("if_gnt", (i % 5 == 4)); pin("cfg_gnt", (i % 5 != 4));
    end
    repeat (3) tick();
    // flush squashes the fetch; loader read still completes
    tick(); fetch(32'h400, 2'b11); pin("if_gnt", 1);
    tick(); flush_i = 1; cfg_req_i = 1; cfg_addr_i = 32'h14; pin("cfg_gnt", 1);
    tick(); pin("if_rvalid", 0);
    tick(); mem_rdata_i = 64'hCAFE_0000_1234_5678;
    pin("cfg_rvalid", 1); pin("cfg_rdata", 64'hCAFE_0000);
    // loader write to upper word
    tick(); cfg_req_i = 1; cfg_we_i = 1; cfg_addr_i = 32'h0C; cfg_wdata_i = 32'hDEADBEEF;
    pin("mem_we", 1); pin("mem_be", 64'hF0); pin("mem_addr", 1);
    pin("mem_wdata", 64'hDEADBEEF_DEADBEEF);
    tick(); pin("cfg_rvalid", 0);
    tick(); pin("cfg_rvalid", 0);
    repeat (2) tick();
    // hold with a fetch in flight, hold exit, reset mid-HOLD
    tick(); fetch(32'h200, 2'b01); pin("if_gnt", 1);
    tick(); hold_i = 1; fetch(32'h208, 2'b01); pin("if_gnt", 0);
    tick(); fetch(32'h208, 2'b01); mem_rdata_i = 64'h5555_6666_7777_8888;
    pin("if_rvalid", 1); pin("if_rdata", 64'h5555_6666_7777_8888); pin("if_gnt", 0);
    tick(); fetch(32'h208, 2'b01); pin("if_gnt", 0);
    tick(); hold_i = 0; fetch(32'h208, 2'b01); pin("if_gnt", 0);
    tick(); fetch(32'h300, 2'b01); pin("if_gnt", 1);
    tick(); hold_i = 1; fetch(32'h308, 2'b01); pin("if_gnt", 0);
    tick();
    tick();
    tick(); rst = 1; fetch(32'h308, 2'b01); cfg_req_i = 1;
    pin("if_gnt", 0); pin("cfg_gnt", 0); pin("mem_req", 0); pin("if_rvalid", 0);
    tick(); rst = 0; hold_i = 0; fetch(32'h500, 2'b11); pin("if_gnt", 1);
    repeat (3) tick();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 3) hold_i = ~hold_i;
      flush_i = ($urandom_range(0, 9) == 0);
      if_req_i = ($urandom_range(0, 9) < 6);
      if_req_2b_i = $urandom_range(0, 1) ? 2'b11 : 2'b01;
      if_addr_i = 32'($urandom_range(0, 255)) << 2;
      cfg_req_i = $urandom_range(0, 1);
      cfg_we_i = ($urandom_range(0, 9) < 3);
      cfg_addr_i = 32'($urandom_range(0, 255)) << 2;
      cfg_wdata_i = $urandom;
    end
    tick(); rst = 0; hold_i = 0;
    repeat (4) tick();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
